// File: rtl/hexout_arbiter_pkg.sv
// hexout_arbiter shared types and constants.
// FSM encoding, ACK timeout and tag field width.
package hexout_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_ACK   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // cycles to wait in ACK for the printer to raise busy
  localparam int ACK_TIMEOUT = 4;
  localparam int ACK_TW      = 2;

  // width of the requester-index tag placed in the word's top nibble
  localparam int TAG_W = 4;

endpackage

// File: rtl/hexout_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Searches from pointer+1 upward, wrapping; first full slot wins.
module hexout_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_full,
  input  logic [IW-1:0]   i_ptr,
  output logic            o_valid,
  output logic [IW-1:0]   o_idx
);

  int w_j;

  // walk offsets high to low so the nearest full slot is written last
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_j     = 0;
    for (int off = NREQ; off >= 1; off--) begin
      w_j = (int'(i_ptr) + off) % NREQ;
      if (i_full[w_j]) begin
        o_valid = 1'b1;
        o_idx   = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/hexout_arbiter.sv
// Round-robin arbiter sharing one hex-dump printer
// among NREQ requesters, each with a one-word slot.
module hexout_arbiter
  import hexout_arbiter_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DW     = 32,
  parameter int TAG_ID = 0,
  localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [NREQ-1:0]   i_req_stb,
  input  logic [NREQ*DW-1:0] i_req_data,
  output logic [NREQ-1:0]   o_req_busy,
  output logic [NREQ-1:0]   o_overrun,
  output logic              o_tx_stb,
  output logic [DW-1:0]     o_tx_data,
  input  logic              i_tx_busy,
  output logic [IW-1:0]     o_grant_id
);

  logic [NREQ-1:0] r_full;
  logic [NREQ-1:0] r_ovr;
  logic [DW-1:0]   r_word [NREQ];
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_grant;
  logic [DW-1:0]   r_tx_data;
  logic            r_tx_stb;
  logic [ACK_TW-1:0] r_tmo;
  state_t          r_state;

  logic            w_valid;
  logic [IW-1:0]   w_idx;
  logic            w_accept;
  logic [DW-1:0]   w_word;
  logic [DW-1:0]   w_issue;

  hexout_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_full  (r_full),
    .i_ptr   (r_ptr),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  assign w_accept = (r_state == S_ISSUE) && !i_tx_busy;
  assign w_word   = r_word[w_idx];

  // optionally overwrite the top nibble with the winner index
  generate
    if (TAG_ID != 0) begin : g_tag
      assign w_issue = {TAG_W'(w_idx), w_word[DW-TAG_W-1:0]};
    end else begin : g_notag
      assign w_issue = w_word;
    end
  endgenerate

  // slot load / overrun detect / clear on printer accept
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_full <= '0;
      r_ovr  <= '0;
      for (int k = 0; k < NREQ; k++) begin
        r_word[k] <= '0;
      end
    end else begin
      r_ovr <= '0;
      for (int k = 0; k < NREQ; k++) begin
        if (i_req_stb[k]) begin
          if (r_full[k]) begin
            r_ovr[k] <= 1'b1;
          end else begin
            r_full[k] <= 1'b1;
            r_word[k] <= i_req_data[k*DW +: DW];
          end
        end
        if (w_accept && (r_grant == IW'(k))) begin
          r_full[k] <= 1'b0;
        end
      end
    end
  end

  // issue FSM: pick, strobe until accepted, then follow printer busy
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_tx_stb  <= 1'b0;
      r_tx_data <= '0;
      r_grant   <= '0;
      r_ptr     <= IW'(NREQ - 1);
      r_tmo     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_valid && !i_tx_busy) begin
            r_tx_data <= w_issue;
            r_grant   <= w_idx;
            r_tx_stb  <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!i_tx_busy) begin
            r_tx_stb <= 1'b0;
            r_ptr    <= r_grant;
            r_tmo    <= '0;
            r_state  <= S_ACK;
          end
        end
        S_ACK: begin
          if (i_tx_busy) begin
            r_state <= S_DRAIN;
          end else if (r_tmo == ACK_TW'(ACK_TIMEOUT - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_DRAIN: begin
          if (!i_tx_busy) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_busy = r_full;
  assign o_overrun  = r_ovr;
  assign o_tx_stb   = r_tx_stb;
  assign o_tx_data  = r_tx_data;
  assign o_grant_id = r_grant;

endmodule

// File: tb/tb_hexout_arbiter.sv
// Directed testbench for hexout_arbiter.
// Printer model: busy one cycle after accept, pr_len cycles long.
module tb_hexout_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_stb = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]   req_busy;
  logic [NREQ-1:0]   overrun;
  logic              tx_stb;
  logic [DW-1:0]     tx_data;
  logic              tx_busy;
  logic [1:0]        grant;

  logic              pr_manual = 1'b0;
  logic              model_busy = 1'b0;
  int                pr_mode = 0;
  int                pr_len = 3;
  int                pr_cnt = 0;

  logic [NREQ-1:0]   t_stb = '0;
  logic [NREQ*DW-1:0] t_data = '0;
  logic [NREQ-1:0]   t_req_busy;
  logic [NREQ-1:0]   t_overrun;
  logic              t_tx_stb;
  logic [DW-1:0]     t_tx_data;
  logic              t_busy = 1'b0;
  logic [1:0]        t_grant;

  int                log_id[$];
  logic [31:0]       log_data[$];

  int errors = 0;
  int checks = 0;

  assign tx_busy = pr_manual | model_busy;

  always #5 clk = ~clk;

  hexout_arbiter #(.NREQ(NREQ), .DW(DW), .TAG_ID(0)) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_req_stb  (req_stb),
    .i_req_data (req_data),
    .o_req_busy (req_busy),
    .o_overrun  (overrun),
    .o_tx_stb   (tx_stb),
    .o_tx_data  (tx_data),
    .i_tx_busy  (tx_busy),
    .o_grant_id (grant)
  );

  hexout_arbiter #(.NREQ(NREQ), .DW(DW), .TAG_ID(1)) dut_tag (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_req_stb  (t_stb),
    .i_req_data (t_data),
    .o_req_busy (t_req_busy),
    .o_overrun  (t_overrun),
    .o_tx_stb   (t_tx_stb),
    .o_tx_data  (t_tx_data),
    .i_tx_busy  (t_busy),
    .o_grant_id (t_grant)
  );

  // printer model and accept log
  always @(posedge clk) begin
    logic acc;
    acc = tx_stb && !tx_busy;
    if (acc) begin
      log_id.push_back(int'(grant));
      log_data.push_back(tx_data);
    end
    #1;
    if (!rst_n) pr_cnt = 0;
    else if (acc && pr_mode == 0) pr_cnt = pr_len;
    else if (pr_cnt > 0) pr_cnt = pr_cnt - 1;
    model_busy = (pr_cnt > 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int k, input logic [31:0] d);
    req_stb[k] = 1'b1;
    req_data[k*DW +: DW] = d;
  endtask

  task automatic wait_log(input int n, input int budget);
    for (int i = 0; i < budget && log_id.size() < n; i++) step();
    checks++;
    if (log_id.size() < n) begin
      errors++;
      $display("FAIL wait_log: got %0d accepts, need %0d", log_id.size(), n);
    end
  endtask

  task automatic do_reset();
    req_stb = '0;
    t_stb = '0;
    pr_manual = 1'b0;
    pr_mode = 0;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    checks++;
    if (req_busy !== 4'b0) begin errors++; $display("FAIL rst_busy: got %b need 0", req_busy); end
    checks++;
    if (overrun !== 4'b0) begin errors++; $display("FAIL rst_ovr: got %b need 0", overrun); end
    checks++;
    if (tx_stb !== 1'b0) begin errors++; $display("FAIL rst_stb: got %b need 0", tx_stb); end
    checks++;
    if (tx_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h need 0", tx_data); end
    checks++;
    if (grant !== 2'd0) begin errors++; $display("FAIL rst_grant: got %0d need 0", grant); end
  endtask

  task automatic test_basic();
    pr_len = 3;
    log_id.delete(); log_data.delete();
    set_word(0, 32'h12345678);
    step();
    req_stb = '0;
    checks++;
    if (req_busy[0] !== 1'b1 || tx_stb !== 1'b0) begin
      errors++; $display("FAIL basic_load: busy0=%b stb=%b need 1,0", req_busy[0], tx_stb);
    end
    step();
    checks++;
    if (tx_stb !== 1'b1) begin errors++; $display("FAIL basic_stb: got %b need 1", tx_stb); end
    checks++;
    if (tx_data !== 32'h12345678) begin errors++; $display("FAIL basic_data: got %h need 12345678", tx_data); end
    checks++;
    if (grant !== 2'd0) begin errors++; $display("FAIL basic_grant: got %0d need 0", grant); end
    step();
    checks++;
    if (req_busy[0] !== 1'b0 || tx_stb !== 1'b0) begin
      errors++; $display("FAIL basic_accept: busy0=%b stb=%b need 0,0", req_busy[0], tx_stb);
    end
    repeat (12) step();
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_d [7];
    int exp_i [7];
    exp_i = '{0, 1, 2, 3, 0, 1, 2};
    exp_d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hB0, 32'hB1, 32'hB2};
    do_reset();
    pr_len = 3;
    log_id.delete(); log_data.delete();
    for (int k = 0; k < 4; k++) set_word(k, 32'hA0 + k);
    step();
    req_stb = '0;
    wait_log(3, 60);
    set_word(1, 32'hB1);
    set_word(2, 32'hB2);
    step();
    req_stb = '0;
    wait_log(4, 60);
    set_word(0, 32'hB0);
    step();
    req_stb = '0;
    wait_log(7, 120);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (i >= log_id.size() || log_id[i] != exp_i[i] || log_data[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL rr_order[%0d]: got id=%0d data=%h need id=%0d data=%h", i,
                 (i < log_id.size()) ? log_id[i] : -1,
                 (i < log_data.size()) ? log_data[i] : 32'hx, exp_i[i], exp_d[i]);
      end
    end
    repeat (12) step();
  endtask

  task automatic test_overrun();
    pr_manual = 1'b1;
    log_id.delete(); log_data.delete();
    set_word(2, 32'hC0);
    step();
    set_word(2, 32'hC1);
    checks++;
    if (overrun !== 4'b0 || req_busy[2] !== 1'b1) begin
      errors++; $display("FAIL ovr_first: ovr=%b busy2=%b need 0000,1", overrun, req_busy[2]);
    end
    step();
    req_stb = '0;
    checks++;
    if (overrun !== 4'b0100) begin errors++; $display("FAIL ovr_pulse1: got %b need 0100", overrun); end
    step();
    checks++;
    if (overrun !== 4'b0) begin errors++; $display("FAIL ovr_clear1: got %b need 0000", overrun); end
    set_word(2, 32'hC2);
    step();
    req_stb = '0;
    checks++;
    if (overrun !== 4'b0100) begin errors++; $display("FAIL ovr_pulse2: got %b need 0100", overrun); end
    step();
    checks++;
    if (overrun !== 4'b0) begin errors++; $display("FAIL ovr_clear2: got %b need 0000", overrun); end
    pr_manual = 1'b0;
    wait_log(1, 40);
    checks++;
    if (log_id.size() < 1 || log_id[0] != 2 || log_data[0] !== 32'hC0) begin
      errors++; $display("FAIL ovr_word: got id=%0d data=%h need id=2 data=c0",
                         (log_id.size() > 0) ? log_id[0] : -1,
                         (log_data.size() > 0) ? log_data[0] : 32'hx);
    end
    repeat (12) step();
  endtask

  task automatic test_busy_hold();
    bit seen;
    pr_manual = 1'b1;
    set_word(1, 32'hD1);
    step();
    req_stb = '0;
    seen = 0;
    repeat (50) begin
      if (tx_stb) seen = 1;
      step();
    end
    checks++;
    if (seen) begin errors++; $display("FAIL hold_nostb: got stb=1 need 0 while busy"); end
    pr_manual = 1'b0;
    step();
    checks++;
    if (tx_stb !== 1'b1 || grant !== 2'd1) begin
      errors++; $display("FAIL hold_release: stb=%b grant=%0d need 1,1", tx_stb, grant);
    end
    checks++;
    if (tx_data !== 32'hD1) begin errors++; $display("FAIL hold_data: got %h need d1", tx_data); end
    repeat (12) step();
  endtask

  task automatic test_ack_timeout();
    pr_mode = 1;
    log_id.delete(); log_data.delete();
    set_word(0, 32'hE0);
    set_word(1, 32'hE1);
    step();
    req_stb = '0;
    wait_log(1, 20);
    checks++;
    if (log_id.size() < 1 || log_id[0] != 0) begin
      errors++; $display("FAIL tmo_first: got id=%0d need 0", (log_id.size() > 0) ? log_id[0] : -1);
    end
    repeat (4) step();
    checks++;
    if (tx_stb !== 1'b0) begin errors++; $display("FAIL tmo_wait: got stb=%b need 0", tx_stb); end
    step();
    checks++;
    if (tx_stb !== 1'b1 || grant !== 2'd1) begin
      errors++; $display("FAIL tmo_next: stb=%b grant=%0d need 1,1", tx_stb, grant);
    end
    wait_log(2, 20);
    repeat (10) step();
    pr_mode = 0;
  endtask

  task automatic test_reset_drain();
    bit seen;
    pr_len = 30;
    log_id.delete(); log_data.delete();
    set_word(0, 32'hF0);
    set_word(1, 32'hF1);
    set_word(2, 32'hF2);
    step();
    req_stb = '0;
    wait_log(1, 20);
    if (log_id.size() > 0) set_word(log_id[0], 32'hF3);
    step();
    req_stb = '0;
    step();
    checks++;
    if (req_busy !== 4'b0111) begin errors++; $display("FAIL drain_full: got %b need 0111", req_busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_busy !== 4'b0 || overrun !== 4'b0 || tx_stb !== 1'b0) begin
      errors++; $display("FAIL drain_rst_ctl: busy=%b ovr=%b stb=%b need 0", req_busy, overrun, tx_stb);
    end
    checks++;
    if (tx_data !== 32'h0 || grant !== 2'd0) begin
      errors++; $display("FAIL drain_rst_dat: data=%h grant=%0d need 0", tx_data, grant);
    end
    repeat (2) step();
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      if (tx_stb) seen = 1;
      step();
    end
    checks++;
    if (seen || req_busy !== 4'b0) begin
      errors++; $display("FAIL drain_after: stb_seen=%0d busy=%b need 0,0000", seen, req_busy);
    end
    pr_len = 3;
  endtask

  task automatic test_tag_id();
    t_data[3*DW +: DW] = 32'hFFFFFFFF;
    t_stb = 4'b1000;
    step();
    t_stb = '0;
    step();
    checks++;
    if (t_tx_stb !== 1'b1) begin errors++; $display("FAIL tag_stb: got %b need 1", t_tx_stb); end
    checks++;
    if (t_tx_data !== 32'h3FFFFFFF) begin errors++; $display("FAIL tag_data: got %h need 3fffffff", t_tx_data); end
    checks++;
    if (t_grant !== 2'd3) begin errors++; $display("FAIL tag_grant: got %0d need 3", t_grant); end
    repeat (8) step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_overrun();
    test_busy_hold();
    test_ack_timeout();
    test_reset_drain();
    test_tag_id();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
